// File: rtl/vending_pkg.sv
// vending_pkg
// Shared definitions for the vending machine slice:
//   - coin input encodings
//   - FSM state encoding
//   - coin_value(): maps a 2-bit coin code to its value in half-units
package vending_pkg;

    // Coin codes as presented on the 2-bit coin input.
    localparam logic [1:0] COIN_NONE = 2'b00;  // no coin
    localparam logic [1:0] COIN_HALF = 2'b01;  // 0.5 -> 1 half-unit
    localparam logic [1:0] COIN_ONE  = 2'b10;  // 1.0 -> 2 half-units
    localparam logic [1:0] COIN_TWO  = 2'b11;  // 2.0 -> 4 half-units

    // FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;   // credit 0, stock > 0
    localparam logic [1:0] ST_CREDIT = 2'd1;   // 0 < credit < PRICE
    localparam logic [1:0] ST_EMPTY  = 2'd2;   // stock 0, credit 0

    // Value of a coin code in half-units (0, 1, 2 or 4).
    function automatic logic [2:0] coin_value(input logic [1:0] c);
        logic [2:0] v;
        case (c)
            COIN_HALF: v = 3'd1;
            COIN_ONE:  v = 3'd2;
            COIN_TWO:  v = 3'd4;
            default:   v = 3'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_stock_counter.sv
// vm_stock_counter
// Item stock counter with a restock load, a single-step decrement and a
// registered empty flag.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (stock -> MAX_STOCK)
//   i_load   in   reload stock to MAX_STOCK
//   i_dec    in   one item dispensed this cycle
//   o_stock  out  items remaining
//   o_empty  out  high while stock is 0
module vm_stock_counter #(
    parameter int MAX_STOCK = 8,
    parameter int SW        = $clog2(MAX_STOCK + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_dec,
    output logic [SW-1:0] o_stock,
    output logic          o_empty
);

    localparam logic [SW-1:0] FULL = SW'(MAX_STOCK);

    logic [SW-1:0] r_stock;
    logic          r_empty;
    logic [SW-1:0] w_next;

    // A load coincident with a decrement means the vend is taken from
    // the freshly loaded stock, leaving MAX_STOCK-1.
    always_comb begin
        w_next = r_stock;
        if (i_load && i_dec) begin
            w_next = FULL - SW'(1);
        end else if (i_load) begin
            w_next = FULL;
        end else if (i_dec && (r_stock != '0)) begin
            w_next = r_stock - SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stock <= FULL;
            r_empty <= 1'b0;
        end else begin
            r_stock <= w_next;
            r_empty <= (w_next == '0);
        end
    end

    assign o_stock = r_stock;
    assign o_empty = r_empty;

endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param
// Single-item vending machine accepting 0.5/1.0/2.0 coins, vending at PRICE
// half-units, returning change and refunding on cancel. All outputs are
// registered: a response to inputs sampled at edge N appears after edge N.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   coin[1:0]     in   coin inserted this cycle (00 none, 01/10/11 = 1/2/4)
//   cancel        in   refund accumulated credit
//   restock       in   reload stock to MAX_STOCK
//   sell          out  one-cycle pulse, item dispensed
//   change_valid  out  one-cycle pulse qualifying change
//   change        out  amount returned in half-units, 0 unless change_valid
//   coin_reject   out  one-cycle pulse, coin returned unaccepted (empty)
//   credit        out  accumulated credit in half-units
//   stock         out  items remaining
//   empty         out  high while stock is 0
//   dbg_state     out  current FSM state (vending_pkg ST_* encoding)
//
// Handshake: there is no backpressure. Each input is a single-cycle
// request sampled on every rising edge; each pulse output is high for
// exactly the one cycle following the edge that caused it.
module vending_machine_param
    import vending_pkg::*;
#(
    parameter int PRICE     = 3,
    parameter int MAX_STOCK = 8,
    parameter int CW        = 4,
    localparam int SW       = $clog2(MAX_STOCK + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          cancel,
    input  logic          restock,
    output logic          sell,
    output logic          change_valid,
    output logic [CW-1:0] change,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic [SW-1:0] stock,
    output logic          empty,
    output logic [1:0]    dbg_state
);

    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);

    logic [1:0]    r_state;
    logic [CW-1:0] r_credit;
    logic          r_sell;
    logic          r_change_valid;
    logic [CW-1:0] r_change;
    logic          r_coin_reject;

    logic [1:0]    w_next_state;
    logic [CW-1:0] w_next_credit;
    logic          w_sell;
    logic          w_change_valid;
    logic [CW-1:0] w_change;
    logic          w_coin_reject;
    logic          w_dec;
    logic [CW-1:0] w_value;
    logic [CW-1:0] w_sum;
    logic          w_active;
    logic          w_last_item;
    logic [SW-1:0] w_stock;
    logic          w_empty;

    // Credit never exceeds PRICE-1 and a coin is at most 4, so the sum
    // fits in CW bits given PRICE+3 < 2**CW.
    assign w_value = CW'(coin_value(coin));
    assign w_sum   = r_credit + w_value;

    // A restock in EMPTY makes the machine serviceable in the same cycle,
    // so the coin is handled as in IDLE instead of being rejected.
    assign w_active = (r_state != ST_EMPTY) || restock;

    // The item vended now is the last one if the stock it is taken from
    // (freshly loaded when restocking) holds exactly one item.
    assign w_last_item = restock ? (MAX_STOCK == 1) : (w_stock == SW'(1));

    always_comb begin
        w_next_state   = r_state;
        w_next_credit  = r_credit;
        w_sell         = 1'b0;
        w_change_valid = 1'b0;
        w_change       = '0;
        w_coin_reject  = 1'b0;
        w_dec          = 1'b0;
        if (!w_active) begin
            if (coin != COIN_NONE) begin
                w_coin_reject = 1'b1;
            end
        end else begin
            if (r_state == ST_EMPTY) begin
                w_next_state = ST_IDLE;
            end
            if (cancel) begin
                // Refund whatever is held plus any coin arriving now.
                if (w_sum != '0) begin
                    w_change_valid = 1'b1;
                    w_change       = w_sum;
                end
                w_next_credit = '0;
                w_next_state  = ST_IDLE;
            end else if (coin != COIN_NONE) begin
                if (w_sum < PRICE_C) begin
                    w_next_credit = w_sum;
                    w_next_state  = ST_CREDIT;
                end else begin
                    w_sell        = 1'b1;
                    w_dec         = 1'b1;
                    w_next_credit = '0;
                    w_next_state  = w_last_item ? ST_EMPTY : ST_IDLE;
                    if (w_sum > PRICE_C) begin
                        w_change_valid = 1'b1;
                        w_change       = w_sum - PRICE_C;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_sell         <= 1'b0;
            r_change_valid <= 1'b0;
            r_change       <= '0;
            r_coin_reject  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_credit       <= w_next_credit;
            r_sell         <= w_sell;
            r_change_valid <= w_change_valid;
            r_change       <= w_change;
            r_coin_reject  <= w_coin_reject;
        end
    end

    vm_stock_counter #(
        .MAX_STOCK (MAX_STOCK),
        .SW        (SW)
    ) u_stock (
        .clk     (clk),
        .rst     (rst),
        .i_load  (restock),
        .i_dec   (w_dec),
        .o_stock (w_stock),
        .o_empty (w_empty)
    );

    assign sell         = r_sell;
    assign change_valid = r_change_valid;
    assign change       = r_change;
    assign coin_reject  = r_coin_reject;
    assign credit       = r_credit;
    assign stock        = w_stock;
    assign empty        = w_empty;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_vending_machine_param.sv
module tb_vending_machine_param;
  import vending_pkg::*;

  localparam int PRICE     = 3;
  localparam int MAX_STOCK = 2;
  localparam int CW        = 4;
  localparam int SW        = $clog2(MAX_STOCK + 1);

  logic          clk;
  logic          rst;
  logic [1:0]    coin;
  logic          cancel;
  logic          restock;
  logic          sell;
  logic          change_valid;
  logic [CW-1:0] change;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic [SW-1:0] stock;
  logic          empty;
  logic [1:0]    dbg_state;

  int n_tests;
  int n_fail;

  // reference model: plain integers, derived from the machine's rules
  int m_credit;
  int m_stock;
  int e_sell;
  int e_cv;
  int e_change;
  int e_reject;
  int coin_half_units[4] = '{0, 1, 2, 4};

  vending_machine_param #(
    .PRICE     (PRICE),
    .MAX_STOCK (MAX_STOCK),
    .CW        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .cancel       (cancel),
    .restock      (restock),
    .sell         (sell),
    .change_valid (change_valid),
    .change       (change),
    .coin_reject  (coin_reject),
    .credit       (credit),
    .stock        (stock),
    .empty        (empty),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_stock  = MAX_STOCK;
    e_sell   = 0;
    e_cv     = 0;
    e_change = 0;
    e_reject = 0;
  endtask

  task automatic model_step(input logic [1:0] c, input logic ca, input logic rs);
    int v;
    int avail;
    int total;
    v = coin_half_units[c];
    e_sell   = 0;
    e_cv     = 0;
    e_change = 0;
    e_reject = 0;
    if (m_stock == 0 && !rs) begin
      if (v > 0) e_reject = 1;
    end else begin
      avail = rs ? MAX_STOCK : m_stock;
      total = m_credit + v;
      m_stock = avail;
      if (ca) begin
        if (total > 0) begin
          e_cv = 1;
          e_change = total;
        end
        m_credit = 0;
      end else if (v > 0) begin
        if (total < PRICE) begin
          m_credit = total;
        end else begin
          e_sell   = 1;
          m_stock  = avail - 1;
          m_credit = 0;
          if (total > PRICE) begin
            e_cv = 1;
            e_change = total - PRICE;
          end
        end
      end
    end
  endtask

  function automatic int exp_state();
    if (m_stock == 0) return int'(ST_EMPTY);
    if (m_credit > 0) return int'(ST_CREDIT);
    return int'(ST_IDLE);
  endfunction

  task automatic check_all(input string phase);
    check_eq({phase, ".sell"},         int'(sell),         e_sell);
    check_eq({phase, ".change_valid"}, int'(change_valid), e_cv);
    check_eq({phase, ".change"},       int'(change),       e_change);
    check_eq({phase, ".coin_reject"},  int'(coin_reject),  e_reject);
    check_eq({phase, ".credit"},       int'(credit),       m_credit);
    check_eq({phase, ".stock"},        int'(stock),        m_stock);
    check_eq({phase, ".empty"},        int'(empty),        (m_stock == 0) ? 1 : 0);
    check_eq({phase, ".state"},        int'(dbg_state),    exp_state());
  endtask

  // driver: apply one cycle of inputs, update model at the edge, compare
  task automatic step(input string phase, input logic [1:0] c, input logic ca, input logic rs);
    @(negedge clk);
    coin    = c;
    cancel  = ca;
    restock = rs;
    @(posedge clk);
    model_step(c, ca, rs);
    #1;
    check_all(phase);
  endtask

  // asynchronous reset: raised mid-cycle, checked before the next edge
  task automatic pulse_reset(input string phase);
    @(negedge clk);
    coin    = COIN_NONE;
    cancel  = 1'b0;
    restock = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(phase);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] rc;
    logic       rca;
    logic       rrs;
    n_tests = 0;
    n_fail  = 0;
    coin    = COIN_NONE;
    cancel  = 1'b0;
    restock = 1'b0;
    rst     = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // three half-unit coins: credit 1, 2, then vend without change
    step("c01a", COIN_HALF, 1'b0, 1'b0);
    check_eq("c01a.credit_is_1", int'(credit), 1);
    step("c01b", COIN_HALF, 1'b0, 1'b0);
    step("c01c", COIN_HALF, 1'b0, 1'b0);
    check_eq("c01c.stock_is_1", int'(stock), 1);
    step("idle", COIN_NONE, 1'b0, 1'b0);

    // 1.0 + 0.5 reaches exactly PRICE; next coin starts a new transaction
    pulse_reset("rst1");
    step("seq2a", COIN_ONE,  1'b0, 1'b0);
    step("seq2b", COIN_HALF, 1'b0, 1'b0);
    step("seq2c", COIN_ONE,  1'b0, 1'b0);

    // 0.5 then 2.0: vend with change 2
    pulse_reset("rst2");
    step("seq3a", COIN_HALF, 1'b0, 1'b0);
    step("seq3b", COIN_TWO,  1'b0, 1'b0);
    check_eq("seq3b.change_is_2", int'(change), 2);

    // sell out, reject a coin, restock
    step("seq4a", COIN_ONE,  1'b0, 1'b0);
    step("seq4b", COIN_TWO,  1'b0, 1'b0);
    check_eq("seq4b.empty_is_1", int'(empty), 1);
    step("seq4c", COIN_ONE,  1'b0, 1'b0);
    step("seq4d", COIN_NONE, 1'b1, 1'b0);
    step("seq4e", COIN_NONE, 1'b0, 1'b1);
    check_eq("seq4e.stock_full", int'(stock), MAX_STOCK);

    // cancel with a coin in the same cycle refunds both
    step("seq5a", COIN_ONE,  1'b0, 1'b0);
    step("seq5b", COIN_HALF, 1'b1, 1'b0);
    check_eq("seq5b.change_is_3", int'(change), 3);
    step("seq5c", COIN_HALF, 1'b1, 1'b0);
    step("seq5d", COIN_NONE, 1'b1, 1'b0);

    // restock coincident with a vend, and with a coin while empty
    step("seq6a", COIN_TWO,  1'b0, 1'b1);
    step("seq6b", COIN_TWO,  1'b0, 1'b0);
    step("seq6c", COIN_TWO,  1'b0, 1'b1);

    // reset mid-transaction discards credit without a refund
    step("seq7a", COIN_HALF, 1'b0, 1'b0);
    pulse_reset("rst7");
    step("seq7b", COIN_NONE, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        rc  = 2'($urandom_range(0, 3));
        rca = ($urandom_range(0, 5) == 0);
        rrs = ($urandom_range(0, 7) == 0);
        // keep cancel away from the restock-while-empty corner
        if (m_stock == 0 && rrs) rca = 1'b0;
        step("rnd", rc, rca, rrs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
